// File: rtl/cmos_cfg_seq.sv
// Camera bring-up sequencer: times sensor pwdn/cam_reset release, then writes each
// register-table entry over a byte-level I2C master, with optional read-back verify and retry.
module cmos_cfg_seq #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned REG_NUM    = 256,
    parameter logic [6:0]  DEV_ADDR   = 7'h3C,
    parameter int unsigned PWDN_CYC   = 100000,
    parameter int unsigned RST_CYC    = 100000,
    parameter int unsigned SETTLE_CYC = 1000000,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned VERIFY     = 0,
    localparam int unsigned IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    output logic [IDX_W-1:0]    tbl_idx,
    input  logic [ADDR_W+7:0]   tbl_data,
    output logic                req,
    output logic [3:0]          cmd,
    output logic [7:0]          dout,
    input  logic [7:0]          din,
    input  logic                done,
    input  logic                slave_ack,
    output logic                pwdn,
    output logic                cam_reset,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic [IDX_W-1:0]    err_idx
);

    localparam int unsigned T_PWDN   = (PWDN_CYC > 0) ? PWDN_CYC - 1 : 0;
    localparam int unsigned T_RST    = (RST_CYC > 0) ? RST_CYC - 1 : 0;
    localparam int unsigned T_SETTLE = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
    localparam int unsigned T_MAX_A  = (T_PWDN > T_RST) ? T_PWDN : T_RST;
    localparam int unsigned T_MAX    = (T_MAX_A > T_SETTLE) ? T_MAX_A : T_SETTLE;
    localparam int unsigned TMR_W    = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;
    localparam int unsigned RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [3:0] C_START = 4'b0001;
    localparam logic [3:0] C_WRITE = 4'b0010;
    localparam logic [3:0] C_READ  = 4'b0100;
    localparam logic [3:0] C_STOP  = 4'b1000;

    typedef enum logic [4:0] {
        S_PWDN, S_RSTW, S_SETTLE, S_LOAD,
        S_W_DEV, S_W_AH, S_W_AL, S_W_DAT,
        S_R_DEV, S_R_AH, S_R_AL, S_R_RS, S_R_DAT,
        S_ABORT, S_FAIL, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [TMR_W-1:0]   r_timer,     w_timer_nxt;
    logic [RTY_W-1:0]   r_retry,     w_retry_nxt;
    logic [15:0]        r_addr,      w_addr_nxt;
    logic [7:0]         r_data,      w_data_nxt;
    logic [IDX_W-1:0]   r_tbl_idx,   w_tbl_idx_nxt;
    logic               r_req,       w_req_nxt;
    logic [3:0]         r_cmd,       w_cmd_nxt;
    logic [7:0]         r_dout,      w_dout_nxt;
    logic               r_pwdn,      w_pwdn_nxt;
    logic               r_cam_reset, w_cam_reset_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               r_done,      w_done_nxt;
    logic               r_err,       w_err_nxt;
    logic [IDX_W-1:0]   r_err_idx,   w_err_idx_nxt;

    // State and output registers; reset wins over everything, including an outstanding byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_PWDN;
            r_timer     <= '0;
            r_retry     <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_tbl_idx   <= '0;
            r_req       <= 1'b0;
            r_cmd       <= '0;
            r_dout      <= '0;
            r_pwdn      <= 1'b1;
            r_cam_reset <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_retry     <= w_retry_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_tbl_idx   <= w_tbl_idx_nxt;
            r_req       <= w_req_nxt;
            r_cmd       <= w_cmd_nxt;
            r_dout      <= w_dout_nxt;
            r_pwdn      <= w_pwdn_nxt;
            r_cam_reset <= w_cam_reset_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_err_idx   <= w_err_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = '0;
        w_retry_nxt     = r_retry;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_tbl_idx_nxt   = r_tbl_idx;
        w_req_nxt       = 1'b0;
        w_cmd_nxt       = r_cmd;
        w_dout_nxt      = r_dout;
        w_pwdn_nxt      = r_pwdn;
        w_cam_reset_nxt = r_cam_reset;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_err_nxt       = r_err;
        w_err_idx_nxt   = r_err_idx;

        case (r_state)
            S_PWDN: begin
                if (r_timer == TMR_W'(T_PWDN)) begin
                    w_state_nxt = S_RSTW;
                    w_pwdn_nxt  = 1'b0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_RSTW: begin
                if (r_timer == TMR_W'(T_RST)) begin
                    w_state_nxt     = S_SETTLE;
                    w_cam_reset_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_SETTLE: begin
                if (r_timer == TMR_W'(T_SETTLE)) w_state_nxt = S_LOAD;
                else                             w_timer_nxt = r_timer + TMR_W'(1);
            end
            // First cycle lets the table ROM catch up with tbl_idx; second cycle latches it.
            S_LOAD: begin
                if (r_timer == '0) begin
                    w_timer_nxt = TMR_W'(1);
                end else begin
                    w_addr_nxt  = 16'(tbl_data[ADDR_W+7:8]);
                    w_data_nxt  = tbl_data[7:0];
                    w_state_nxt = S_W_DEV;
                end
            end
            S_W_DEV: if (done) w_state_nxt = !slave_ack ? S_ABORT : ((ADDR_W == 16) ? S_W_AH : S_W_AL);
            S_W_AH:  if (done) w_state_nxt = slave_ack ? S_W_AL : S_ABORT;
            S_W_AL:  if (done) w_state_nxt = slave_ack ? S_W_DAT : S_ABORT;
            // The data byte already carries STOP, so a NACK here skips the abort byte.
            S_W_DAT: if (done) w_state_nxt = !slave_ack ? S_FAIL : ((VERIFY != 0) ? S_R_DEV : S_NEXT);
            S_R_DEV: if (done) w_state_nxt = !slave_ack ? S_ABORT : ((ADDR_W == 16) ? S_R_AH : S_R_AL);
            S_R_AH:  if (done) w_state_nxt = slave_ack ? S_R_AL : S_ABORT;
            S_R_AL:  if (done) w_state_nxt = slave_ack ? S_R_RS : S_ABORT;
            S_R_RS:  if (done) w_state_nxt = slave_ack ? S_R_DAT : S_ABORT;
            S_R_DAT: if (done) w_state_nxt = (din == r_data) ? S_NEXT : S_FAIL;
            S_ABORT: if (done) w_state_nxt = S_FAIL;
            S_FAIL: begin
                if (r_retry < RTY_W'(MAX_RETRY)) begin
                    w_retry_nxt = r_retry + RTY_W'(1);
                    w_state_nxt = S_W_DEV;
                end else begin
                    w_err_nxt     = 1'b1;
                    w_err_idx_nxt = r_tbl_idx;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = S_ERR;
                end
            end
            S_NEXT: begin
                w_retry_nxt = '0;
                if (r_tbl_idx == IDX_W'(REG_NUM - 1)) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_tbl_idx_nxt = r_tbl_idx + IDX_W'(1);
                    w_state_nxt   = S_LOAD;
                end
            end
            S_DONE, S_ERR: begin
                if (cfg_start) begin
                    w_done_nxt    = 1'b0;
                    w_err_nxt     = 1'b0;
                    w_err_idx_nxt = '0;
                    w_retry_nxt   = '0;
                    w_tbl_idx_nxt = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_LOAD;
                end
            end
            default: w_state_nxt = S_PWDN;
        endcase

        // Each byte state fires its single request on entry, so req can never repeat before done.
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                S_W_DEV, S_R_DEV: begin w_req_nxt = 1'b1; w_cmd_nxt = C_START | C_WRITE; w_dout_nxt = {DEV_ADDR, 1'b0}; end
                S_W_AH,  S_R_AH:  begin w_req_nxt = 1'b1; w_cmd_nxt = C_WRITE;           w_dout_nxt = r_addr[15:8];     end
                S_W_AL,  S_R_AL:  begin w_req_nxt = 1'b1; w_cmd_nxt = C_WRITE;           w_dout_nxt = r_addr[7:0];      end
                S_W_DAT:          begin w_req_nxt = 1'b1; w_cmd_nxt = C_WRITE | C_STOP;  w_dout_nxt = r_data;           end
                S_R_RS:           begin w_req_nxt = 1'b1; w_cmd_nxt = C_START | C_WRITE; w_dout_nxt = {DEV_ADDR, 1'b1}; end
                S_R_DAT:          begin w_req_nxt = 1'b1; w_cmd_nxt = C_READ | C_STOP;   w_dout_nxt = 8'h00;            end
                S_ABORT:          begin w_req_nxt = 1'b1; w_cmd_nxt = C_STOP;            w_dout_nxt = 8'h00;            end
                default: ;
            endcase
        end
    end

    assign tbl_idx   = r_tbl_idx;
    assign req       = r_req;
    assign cmd       = r_cmd;
    assign dout      = r_dout;
    assign pwdn      = r_pwdn;
    assign cam_reset = r_cam_reset;
    assign cfg_busy  = r_busy;
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;
    assign err_idx   = r_err_idx;

endmodule
